// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Merges the CPU instruction-fetch port (imem_*) and the load/store port (dmem_*)
// onto one word-wide downstream memory interface (mem_*). One transaction at a
// time: the winner's address/data/mask are latched, the downstream strobe is held
// until mem_resp, and the read data plus a one-cycle resp pulse go back to the owner.
// The data port has priority over fetch.
//
// Optional build macro: MEM_ARB_FAIRNESS_EN
//   When defined, a 4-bit starve counter counts D grants issued while imem_read is
//   high; once it reaches STARVE_LIMIT and both ports request, fetch wins.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   imem_read/imem_address          fetch request (held until imem_resp)
//   imem_rdata/imem_resp            fetch data and one-cycle completion pulse
//   dmem_read/dmem_write            load/store request (held until dmem_resp)
//   dmem_address/dmem_wdata         data address and store data
//   dmem_byte_enable                store byte mask
//   dmem_rdata/dmem_resp            load data and one-cycle completion pulse
//   mem_read/mem_write              downstream strobes, held until mem_resp
//   mem_address/mem_wdata           latched downstream address and store data
//   mem_byte_enable                 latched mask (2'b11 on reads)
//   mem_rdata/mem_resp              downstream read data and completion pulse
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              imem_read,
   input  logic [ADDR_W-1:0] imem_address,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              imem_resp,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [ADDR_W-1:0] dmem_address,
   input  logic [DATA_W-1:0] dmem_wdata,
   input  logic [1:0]        dmem_byte_enable,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_byte_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   // Out-of-range limits are rejected at elaboration.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDone} state_e;

   state_e            state_q, state_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        mem_be_q, mem_be_d;
   logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
   logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
   logic              imem_resp_q, imem_resp_d;
   logic              dmem_resp_q, dmem_resp_d;

   logic d_req;
   logic i_wins;

   assign d_req = dmem_read | dmem_write;

`ifdef MEM_ARB_FAIRNESS_EN
   logic [3:0] starve_q, starve_d;

   assign i_wins = imem_read & (~d_req | (starve_q == 4'(STARVE_LIMIT)));

   always_comb begin
      starve_d = starve_q;
      if (state_q == StIdle) begin
         if (i_wins) begin
            starve_d = 4'd0;
         end else if (d_req) begin
            // Only D grants that made a waiting fetch wait count toward starvation.
            starve_d = imem_read ? starve_q + 4'd1 : 4'd0;
         end
      end
   end
`else
   assign i_wins = imem_read & ~d_req;
`endif

   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_d      = mem_be_q;
      imem_rdata_d  = imem_rdata_q;
      dmem_rdata_d  = dmem_rdata_q;
      imem_resp_d   = 1'b0;
      dmem_resp_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_wins) begin
               state_d       = StGrantI;
               mem_read_d    = 1'b1;
               mem_address_d = imem_address;
               mem_be_d      = 2'b11;
            end else if (d_req) begin
               state_d       = StGrantD;
               // Read and write together is treated as a write.
               mem_write_d   = dmem_write;
               mem_read_d    = ~dmem_write;
               mem_address_d = dmem_address;
               mem_wdata_d   = dmem_wdata;
               mem_be_d      = dmem_write ? dmem_byte_enable : 2'b11;
            end
         end
         StGrantI: begin
            if (mem_resp) begin
               state_d    = StDone;
               mem_read_d = 1'b0;
               // A dropped (flushed) fetch still completes downstream but is not reported.
               if (imem_read) begin
                  imem_rdata_d = mem_rdata;
                  imem_resp_d  = 1'b1;
               end
            end
         end
         StGrantD: begin
            if (mem_resp) begin
               state_d     = StDone;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (d_req) begin
                  dmem_rdata_d = mem_rdata;
                  dmem_resp_d  = 1'b1;
               end
            end
         end
         StDone: begin
            // Gap cycle lets the requester drop its request after resp.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_be_q      <= 2'b00;
         imem_rdata_q  <= '0;
         dmem_rdata_q  <= '0;
         imem_resp_q   <= 1'b0;
         dmem_resp_q   <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
         starve_q      <= 4'd0;
`endif
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_q      <= mem_be_d;
         imem_rdata_q  <= imem_rdata_d;
         dmem_rdata_q  <= dmem_rdata_d;
         imem_resp_q   <= imem_resp_d;
         dmem_resp_q   <= dmem_resp_d;
`ifdef MEM_ARB_FAIRNESS_EN
         starve_q      <= starve_d;
`endif
      end
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = mem_address_q;
   assign mem_wdata       = mem_wdata_q;
   assign mem_byte_enable = mem_be_q;
   assign imem_rdata      = imem_rdata_q;
   assign dmem_rdata      = dmem_rdata_q;
   assign imem_resp       = imem_resp_q;
   assign dmem_resp       = dmem_resp_q;

endmodule
